num_entry: RTL and testbench
============================

Name: num_entry

Overview:
- Keypad-side producer of `calc_pkg::num_t` operands for the ALU.
- Accumulates digit, decimal-point, sign, clear and enter keystrokes into an in-progress number.
- On enter, presents the finished normalized number on a valid/ready output, the same handshake the ALU operand inputs consume.
- Also exposes a live preview of the number being typed, for the display.

Parameters:
- NumDigits, default `calc_pkg::NumDigits`: BCD significand digits. Test plan uses 8.
- MaxExp, default `2**$bits(calc_pkg::num_t.exponent)-1`: largest encodable exponent. Test plan uses 7.

Ports:
- `clk_i`  in  1  clock
- `rst_i`  in  1  synchronous active-high reset
- `key_code_i`  in  4  0-9 digit, 10 point, 11 sign toggle, 12 enter, 13 clear, 14 backspace, 15 reserved/ignored
- `key_valid_i`  in  1  key present
- `key_ready_o`  out  1  key accepted this cycle when `key_valid_i && key_ready_o`
- `entry_o`  out  num_t  live preview of the current entry, registered
- `num_o`  out  num_t  finished number, registered
- `out_valid_o`  out  1  `num_o` valid
- `out_ready_i`  in  1  consumer accepts `num_o`

Behaviour:
- Number format: value = (-1)^sign × 0.d[N-1]d[N-2]…d[0] × 10^exponent.
  - `significand[NumDigits-1]` is the first digit typed.
  - exponent>0 ⇒ `significand[NumDigits-1]` != 0.
  - exponent 0 may carry leading zeros.
- Internal state:
  - digit buffer
  - cnt (0..N): digits stored
  - has_pt
  - pt: integer-digit count; tracks cnt while !has_pt
  - sign
  - FSM {ENTRY, EMIT}
- Reset (`rst_i` high at a posedge):
  - FSM=ENTRY; buffer, cnt, pt, has_pt, sign cleared.
  - `key_ready_o`=0 while `rst_i` is high, 1 on the first cycle after reset.
  - `out_valid_o`=0; `num_o`=0; `entry_o`=+0 exponent 0.
  - Reset during EMIT drops the pending number.
- ENTRY: `key_ready_o`=1. For each accepted key:
  - Digit, zero with cnt==0 and !has_pt: ignored (no leading integer zeros).
  - Digit, cnt==N: ignored (saturate).
  - Digit, otherwise: stored at index N-1-cnt; cnt++; pt=cnt if !has_pt.
  - Point: sets has_pt; ignored if has_pt is already set.
  - Sign: toggles sign.
  - Clear: buffer, cnt, pt, has_pt, sign all cleared.
  - Enter: loads `num_o` as follows, then FSM→EMIT.
    - significand = buffer; exponent = pt.
    - sign = sign, forced to 0 if all digits are zero.
    - error = (pt > MaxExp); when error=1, exponent=MaxExp and the significand is kept.
  - Backspace:
    - With `NUM_ENTRY_BACKSPACE_EN` compiled in: see Optional Feature.
    - Without it: ignored.
- `entry_o`: updated on the cycle after each accepted key, using the same formula as enter, including error.
- EMIT: `key_ready_o`=0; `out_valid_o`=1; `num_o` held stable.
  - On `out_valid_o && out_ready_i`: next cycle `out_valid_o`=0, FSM=ENTRY, and state is cleared as for the clear key.
  - Latency: enter accepted at edge k ⇒ `out_valid_o`=1 after edge k. Handshake at edge m ⇒ `key_ready_o`=1 after edge m. No bubble beyond that.
- `out_valid_o` never drops without a handshake, except on reset.

Optional Feature:
- Macro: `NUM_ENTRY_BACKSPACE_EN`.
- With the macro defined, backspace (code 14) in ENTRY:
  - if has_pt and cnt==pt: clear has_pt;
  - else if cnt>0: zero digit N-cnt, cnt--, and pt=cnt if !has_pt;
  - else: no-op.
- Without the macro: code 14 is accepted and ignored.

Test Plan:
- Keys 1,2,3,enter; `out_ready_i`=1 → `num_o` = +, sig [1,2,3,0,0,0,0,0], exp 3, error 0; `key_ready_o` returns 1 the cycle after the handshake.
- Keys 0,point,0,5,sign,enter → `num_o` = −, sig [0,5,0,0,0,0,0,0], exp 0.
- Keys 9 ×9 (9th ignored),enter → sig all 9, pt 8 > 7 ⇒ error=1, exp 7. Keys point,point,7,enter → sig [7,0,…], exp 0, no error.
- Enter with empty entry after sign → +0, exp 0. Hold `out_ready_i`=0 for 5 cycles → `out_valid_o` stays 1, `num_o` stable, `key_ready_o`=0 and keys are dropped.
- Keys 4,5,clear,6,enter → sig [6,0,…], exp 1. Assert `rst_i` during EMIT → `out_valid_o`=0 next cycle; following enter gives +0.
- `NUM_ENTRY_BACKSPACE_EN`: keys 1,2,point,3,backspace,backspace,4,enter → sig [1,2,4,0,…], exp 3. Without the macro: same keys → sig [1,2,3,4,0,…], exp 2.

Source files
------------

// File: rtl/num_entry.sv
// num_entry: keypad-side operand builder for the calculator ALU.
// Collects digit / point / sign / clear / enter keystrokes into a BCD number,
// shows a live preview on entry_o, and hands the finished number out on a
// valid/ready port (num_o / out_valid_o / out_ready_i).
// Optional feature: define NUM_ENTRY_BACKSPACE_EN to make key 14 a backspace;
// otherwise key 14 is accepted and ignored.

package calc_pkg;
   localparam int NumDigits = 8;
   localparam int ExpW      = 3;

   // value = (-1)^sign * 0.d[N-1]..d[0] * 10^exponent
   typedef struct packed {
      logic                      sign;
      logic                      error;
      logic [ExpW-1:0]           exponent;
      logic [NumDigits-1:0][3:0] significand;
   } num_t;
endpackage

module num_entry #(
   parameter int NumDigits = calc_pkg::NumDigits,
   parameter int MaxExp    = 2**calc_pkg::ExpW - 1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [3:0]      key_code_i,
   input  logic            key_valid_i,
   output logic            key_ready_o,
   output calc_pkg::num_t  entry_o,
   output calc_pkg::num_t  num_o,
   output logic            out_valid_o,
   input  logic            out_ready_i
);

   localparam int ExpW = calc_pkg::ExpW;
   localparam int CntW = $clog2(NumDigits + 1);
   localparam int IdxW = $clog2(NumDigits);

   localparam logic [3:0] KeyPoint = 4'd10;
   localparam logic [3:0] KeySign  = 4'd11;
   localparam logic [3:0] KeyEnter = 4'd12;
   localparam logic [3:0] KeyClear = 4'd13;
   localparam logic [3:0] KeyBksp  = 4'd14;

   typedef logic [NumDigits-1:0][3:0] sig_t;

   typedef enum logic {
      ST_ENTRY = 1'b0,
      ST_EMIT  = 1'b1
   } state_t;

   // Architectural state
   state_t              r_state;
   sig_t                r_buf;
   logic [CntW-1:0]     r_cnt;
   logic [CntW-1:0]     r_pt;
   logic                r_has_pt;
   logic                r_sign;
   calc_pkg::num_t      r_num;
   calc_pkg::num_t      r_entry;

   // Next-state values
   state_t              w_state_nxt;
   sig_t                w_buf_nxt;
   logic [CntW-1:0]     w_cnt_nxt;
   logic [CntW-1:0]     w_pt_nxt;
   logic                w_has_pt_nxt;
   logic                w_sign_nxt;
   logic                w_load;
   logic                w_clear;
   logic                w_key_acc;
   logic                w_is_digit;
   logic                w_digit_ok;
   logic [IdxW-1:0]     w_wr_idx;
`ifdef NUM_ENTRY_BACKSPACE_EN
   logic [IdxW-1:0]     w_bs_idx;
`endif

   // Integer-digit count clamps at MaxExp; the clamp is what flags an error.
   function automatic logic exp_overflow(input logic [CntW-1:0] pt);
      return int'(pt) > MaxExp;
   endfunction

   function automatic logic [ExpW-1:0] sat_exp(input logic [CntW-1:0] pt);
      if (exp_overflow(pt)) begin
         return ExpW'(MaxExp);
      end
      return ExpW'(pt);
   endfunction

   // Normalized view of an in-progress entry; shared by preview and enter so
   // the two can never disagree. Negative zero is folded to +0.
   function automatic calc_pkg::num_t fmt_num(input sig_t            sig,
                                              input logic [CntW-1:0] pt,
                                              input logic            sgn);
      calc_pkg::num_t n;
      n             = '0;
      n.significand = sig;
      n.exponent    = sat_exp(pt);
      n.error       = exp_overflow(pt);
      n.sign        = sgn && (sig != '0);
      return n;
   endfunction

   assign w_key_acc  = key_valid_i && key_ready_o;
   assign w_is_digit = (key_code_i <= 4'd9);
   // A digit is stored unless it is a leading integer zero or the buffer is full.
   assign w_digit_ok = !((key_code_i == 4'd0) && (r_cnt == '0) && !r_has_pt) &&
                       (int'(r_cnt) != NumDigits);
   assign w_wr_idx   = IdxW'(NumDigits - 1 - int'(r_cnt));
`ifdef NUM_ENTRY_BACKSPACE_EN
   // Last stored digit sits one position above the next write slot.
   assign w_bs_idx   = IdxW'(NumDigits - int'(r_cnt));
`endif

   // Keys are refused while in reset and while a finished number is pending.
   assign key_ready_o = (r_state == ST_ENTRY) && !rst_i;
   assign out_valid_o = (r_state == ST_EMIT);
   assign num_o       = r_num;
   assign entry_o     = r_entry;

   // Next-state logic: keystroke decode in ENTRY, handshake wait in EMIT.
   always_comb begin
      w_state_nxt  = r_state;
      w_buf_nxt    = r_buf;
      w_cnt_nxt    = r_cnt;
      w_pt_nxt     = r_pt;
      w_has_pt_nxt = r_has_pt;
      w_sign_nxt   = r_sign;
      w_load       = 1'b0;
      w_clear      = 1'b0;

      unique case (r_state)
         ST_ENTRY: begin
            if (w_key_acc) begin
               if (w_is_digit) begin
                  if (w_digit_ok) begin
                     w_buf_nxt[w_wr_idx] = key_code_i;
                     w_cnt_nxt           = r_cnt + CntW'(1);
                     if (!r_has_pt) begin
                        w_pt_nxt = r_cnt + CntW'(1);
                     end
                  end
               end else begin
                  case (key_code_i)
                     KeyPoint: w_has_pt_nxt = 1'b1;
                     KeySign:  w_sign_nxt   = !r_sign;
                     KeyEnter: begin
                        w_load      = 1'b1;
                        w_state_nxt = ST_EMIT;
                     end
                     KeyClear: w_clear = 1'b1;
                     KeyBksp: begin
`ifdef NUM_ENTRY_BACKSPACE_EN
                        // Undo the point first if nothing was typed after it.
                        if (r_has_pt && (r_cnt == r_pt)) begin
                           w_has_pt_nxt = 1'b0;
                        end else if (r_cnt != '0) begin
                           w_buf_nxt[w_bs_idx] = 4'd0;
                           w_cnt_nxt           = r_cnt - CntW'(1);
                           if (!r_has_pt) begin
                              w_pt_nxt = r_cnt - CntW'(1);
                           end
                        end
`endif
                     end
                     default: ;
                  endcase
               end
            end
         end
         ST_EMIT: begin
            if (out_ready_i) begin
               w_state_nxt = ST_ENTRY;
               w_clear     = 1'b1;
            end
         end
         default: w_state_nxt = ST_ENTRY;
      endcase

      if (w_clear) begin
         w_buf_nxt    = '0;
         w_cnt_nxt    = '0;
         w_pt_nxt     = '0;
         w_has_pt_nxt = 1'b0;
         w_sign_nxt   = 1'b0;
      end
   end

   // State register plus registered output/preview; reset drops any pending number.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state  <= ST_ENTRY;
         r_buf    <= '0;
         r_cnt    <= '0;
         r_pt     <= '0;
         r_has_pt <= 1'b0;
         r_sign   <= 1'b0;
         r_num    <= '0;
         r_entry  <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_buf    <= w_buf_nxt;
         r_cnt    <= w_cnt_nxt;
         r_pt     <= w_pt_nxt;
         r_has_pt <= w_has_pt_nxt;
         r_sign   <= w_sign_nxt;
         r_entry  <= fmt_num(w_buf_nxt, w_pt_nxt, w_sign_nxt);
         if (w_load) begin
            r_num <= fmt_num(r_buf, r_pt, r_sign);
         end
      end
   end

endmodule

// File: tb/tb_num_entry.sv
// Scoreboard bench for num_entry: expected numbers are queued at enter time and
// a negedge monitor compares them whenever an output handshake happens.
module tb_num_entry;
   import calc_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_ready;
   num_t       entry;
   num_t       num;
   logic       out_valid;
   logic       out_ready;

   int   n_checks = 0;
   int   n_pass   = 0;
   num_t exp_q[$];

   always #5 clk = ~clk;

   num_entry #(.NumDigits(8), .MaxExp(7)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .key_code_i  (key_code),
      .key_valid_i (key_valid),
      .key_ready_o (key_ready),
      .entry_o     (entry),
      .num_o       (num),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready)
   );

   function automatic num_t mk(input logic s, input logic e, input int ex,
                               input logic [31:0] sig);
      num_t n;
      n.sign        = s;
      n.error       = e;
      n.exponent    = 3'(ex);
      n.significand = sig;
      return n;
   endfunction

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, req);
   endtask

   // Monitor: every accepted output must match the oldest queued expectation.
   always @(negedge clk) begin : monitor
      num_t e;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_output: got %h expected none", num);
         end else begin
            e = exp_q.pop_front();
            check("num_o", 64'(num), 64'(e));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic key(input logic [3:0] c);
      int w;
      w = 0;
      while (key_ready !== 1'b1 && w < 20) begin
         tick();
         w++;
      end
      if (key_ready !== 1'b1) check("key_ready_timeout", 64'(key_ready), 64'd1);
      key_code  = c;
      key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
   endtask

   task automatic enter_push(input num_t e);
      exp_q.push_back(e);
      key(4'd12);
      check("out_valid_after_enter", 64'(out_valid), 64'd1);
      check("key_ready_in_emit", 64'(key_ready), 64'd0);
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (exp_q.size() != 0 && w < 30) begin
         tick();
         w++;
      end
      if (exp_q.size() != 0) begin
         n_checks++;
         $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      num_t e_bs;
      rst       = 1'b1;
      key_valid = 1'b0;
      key_code  = 4'd0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_key_ready", 64'(key_ready), 64'd0);
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_num", 64'(num), 64'd0);
      check("reset_entry", 64'(entry), 64'd0);
      rst = 1'b0;
      #1;
      check("key_ready_after_reset", 64'(key_ready), 64'd1);

      // 1,2,(15 ignored),3 -> +0.123 e3; ready returns right after handshake
      key(4'd1); key(4'd2);
      check("preview_12", 64'(entry), 64'(mk(0, 0, 2, 32'h12000000)));
      key(4'd15); key(4'd3);
      enter_push(mk(0, 0, 3, 32'h12300000));
      tick();
      check("key_ready_after_hs", 64'(key_ready), 64'd1);
      check("out_valid_after_hs", 64'(out_valid), 64'd0);
      check("entry_cleared_after_hs", 64'(entry), 64'd0);

      // 0,point,0,5,sign -> -0.05 e0
      key(4'd0); key(4'd10); key(4'd0); key(4'd5); key(4'd11);
      check("preview_neg", 64'(entry), 64'(mk(1, 0, 0, 32'h05000000)));
      enter_push(mk(1, 0, 0, 32'h05000000));
      drain();

      // nine 9s: saturate at 8 digits, exponent 8 overflows to 7 with error
      repeat (9) key(4'd9);
      check("preview_err", 64'(entry), 64'(mk(0, 1, 7, 32'h99999999)));
      enter_push(mk(0, 1, 7, 32'h99999999));
      drain();
      key(4'd10); key(4'd10); key(4'd7);
      enter_push(mk(0, 0, 0, 32'h70000000));
      drain();

      // sign then enter on empty entry -> +0; stall five cycles
      out_ready = 1'b0;
      key(4'd11);
      enter_push(mk(0, 0, 0, 32'h0));
      for (int i = 0; i < 5; i++) begin
         key_code  = 4'd5;
         key_valid = 1'b1;
         tick();
         check("stall_valid", 64'(out_valid), 64'd1);
         check("stall_num", 64'(num), 64'(mk(0, 0, 0, 32'h0)));
         check("stall_key_ready", 64'(key_ready), 64'd0);
      end
      key_valid = 1'b0;
      check("stall_key_dropped", 64'(entry), 64'd0);
      out_ready = 1'b1;
      drain();

      // 4,5,clear,6 -> +0.6 e1
      key(4'd4); key(4'd5); key(4'd13); key(4'd6);
      enter_push(mk(0, 0, 1, 32'h60000000));
      drain();

      // reset while a number is pending drops it
      out_ready = 1'b0;
      key(4'd7); key(4'd12);
      check("pending_valid", 64'(out_valid), 64'd1);
      check("pending_num", 64'(num), 64'(mk(0, 0, 1, 32'h70000000)));
      rst = 1'b1;
      tick();
      check("rst_emit_valid", 64'(out_valid), 64'd0);
      check("rst_emit_num", 64'(num), 64'd0);
      check("rst_emit_key_ready", 64'(key_ready), 64'd0);
      rst       = 1'b0;
      out_ready = 1'b1;
      enter_push(mk(0, 0, 0, 32'h0));
      drain();

      // backspace sequence: 1,2,point,3,bksp,bksp,4
`ifdef NUM_ENTRY_BACKSPACE_EN
      e_bs = mk(0, 0, 3, 32'h12400000);
`else
      e_bs = mk(0, 0, 2, 32'h12340000);
`endif
      key(4'd1); key(4'd2); key(4'd10); key(4'd3);
      key(4'd14); key(4'd14); key(4'd4);
      check("preview_bksp", 64'(entry), 64'(e_bs));
      enter_push(e_bs);
      drain();

      tick();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
